// File: rtl/clk_set_ctrl_pkg.sv
// Shared types and helpers for the RTC time-base / time-set controller.
// State encodings double as the externally visible mode value.
package clk_set_ctrl_pkg;

    localparam int unsigned TIME_W = 6;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_MIN = 2'd1,
        ST_SET_SEC = 2'd2
    } state_t;

    // Modular step of an edit field: up wraps max_val->0, down wraps 0->max_val.
    function automatic logic [TIME_W-1:0] wrap_step(input logic [TIME_W-1:0] val,
                                                    input logic              up,
                                                    input logic [TIME_W-1:0] max_val);
        logic [TIME_W-1:0] res;
        if (up) begin
            res = (val >= max_val) ? '0 : val + TIME_W'(1);
        end else begin
            res = (val == '0) ? max_val : val - TIME_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_set_prescaler.sv
// Terminal-count divider: counts 0..DIV-1 while clr is low, held at 0 while clr is high.
// wrap_c is high during the last count of each period.
module clk_set_prescaler #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic wrap_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign wrap_c = (count == LAST) && !clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_set_ctrl.sv
// RTC time-base and time-set controller: 1 Hz enable, RUN/SET_MIN/SET_SEC editing, load strobe.
// Optional field blink output enabled by defining CLK_SET_BLINK_EN.
module clk_set_ctrl
    import clk_set_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned MAX_VAL  = 59
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [TIME_W-1:0] cur_seconds,
    input  logic [TIME_W-1:0] cur_minutes,
    output logic              tick_1hz,
    output logic              load,
    output logic [TIME_W-1:0] load_seconds,
    output logic [TIME_W-1:0] load_minutes,
    output logic [1:0]        mode
`ifdef CLK_SET_BLINK_EN
    ,
    output logic              blink
`endif
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_VAL);

    state_t            state;
    logic [TIME_W-1:0] edit_sec;
    logic [TIME_W-1:0] edit_min;
    logic              tick_clr_c;
    logic              tick_wrap_c;
    logic              edit_c;

    // Hold the time base outside RUN, including the edge that leaves RUN.
    assign tick_clr_c = (state != ST_RUN) || btn_mode;
    assign edit_c     = (btn_inc ^ btn_dec) && !btn_mode && (state != ST_RUN);
    assign mode       = state;

    clk_set_prescaler #(.DIV(TICK_DIV)) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tick_clr_c),
        .wrap_c  (tick_wrap_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RUN;
            edit_sec     <= '0;
            edit_min     <= '0;
            tick_1hz     <= 1'b0;
            load         <= 1'b0;
            load_seconds <= '0;
            load_minutes <= '0;
        end else begin
            load     <= 1'b0;
            tick_1hz <= tick_wrap_c;
            if (btn_mode) begin
                // Mode button wins over any simultaneous inc/dec.
                case (state)
                    ST_RUN: begin
                        state    <= ST_SET_MIN;
                        edit_sec <= cur_seconds;
                        edit_min <= cur_minutes;
                    end
                    ST_SET_MIN: state <= ST_SET_SEC;
                    ST_SET_SEC: begin
                        state        <= ST_RUN;
                        load         <= 1'b1;
                        load_seconds <= edit_sec;
                        load_minutes <= edit_min;
                    end
                    default: state <= ST_RUN;
                endcase
            end else if (edit_c) begin
                case (state)
                    ST_SET_MIN: edit_min <= wrap_step(edit_min, btn_inc, MAX_T);
                    ST_SET_SEC: edit_sec <= wrap_step(edit_sec, btn_inc, MAX_T);
                    default: ;
                endcase
            end
        end
    end

`ifdef CLK_SET_BLINK_EN
    logic blink_clr_c;
    logic blink_wrap_c;

    // Restart on any state change or edit so the new value is shown at once.
    assign blink_clr_c = (state == ST_RUN) || btn_mode || edit_c;

    clk_set_prescaler #(.DIV(TICK_DIV / 4)) u_blink_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (blink_clr_c),
        .wrap_c  (blink_wrap_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink <= 1'b0;
        end else if (blink_clr_c) begin
            blink <= 1'b0;
        end else if (blink_wrap_c) begin
            blink <= ~blink;
        end
    end
`endif

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Directed self-checking bench for clk_set_ctrl with TICK_DIV=8.
// Blink checks are compiled in only when CLK_SET_BLINK_EN is defined.
module tb_clk_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [5:0] cur_seconds = '0;
    logic [5:0] cur_minutes = '0;
    logic       tick_1hz;
    logic       load;
    logic [5:0] load_seconds;
    logic [5:0] load_minutes;
    logic [1:0] mode;
`ifdef CLK_SET_BLINK_EN
    logic       blink;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    clk_set_ctrl #(.TICK_DIV(8), .MAX_VAL(59)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .cur_seconds  (cur_seconds),
        .cur_minutes  (cur_minutes),
        .tick_1hz     (tick_1hz),
        .load         (load),
        .load_seconds (load_seconds),
        .load_minutes (load_minutes),
        .mode         (mode)
`ifdef CLK_SET_BLINK_EN
        ,
        .blink        (blink)
`endif
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    task automatic chk_load(input string tag, input int unsigned mins, input int unsigned secs);
        chk({tag, "_load"}, load, 1);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_min"}, load_minutes, mins);
        chk({tag, "_sec"}, load_seconds, secs);
        step();
        chk({tag, "_load_drop"}, load, 0);
        chk({tag, "_min_hold"}, load_minutes, mins);
    endtask

    initial begin
        // 1: reset state, then free-running tick every 8 cycles
        #50;
        chk("rst_tick", tick_1hz, 0);
        chk("rst_load", load, 0);
        chk("rst_mode", mode, 0);
        chk("rst_lsec", load_seconds, 0);
        chk("rst_lmin", load_minutes, 0);
        #50;
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("run_tick", tick_1hz, (i % 8 == 0) ? 1 : 0);
            chk("run_mode", mode, 0);
        end

        // 2: 12:34 -> edit to 15:32, load, tick 8 cycles after load
        cur_minutes = 6'd12;
        cur_seconds = 6'd34;
        press(1, 0, 0);
        chk("set_min_mode", mode, 1);
        for (int i = 0; i < 3; i++) begin
            press(0, 1, 0);
            chk("set_min_tick", tick_1hz, 0);
        end
        press(1, 0, 0);
        chk("set_sec_mode", mode, 2);
        press(0, 0, 1);
        press(0, 0, 1);
        press(1, 0, 0);
        chk("t2_load_now", load, 1);
        chk("t2_mode", mode, 0);
        chk("t2_min", load_minutes, 15);
        chk("t2_sec", load_seconds, 32);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t2_tick", tick_1hz, (i == 8) ? 1 : 0);
            chk("t2_noload", load, 0);
        end

        // 3: wrap in both fields and both directions
        cur_minutes = 6'd59;
        cur_seconds = 6'd0;
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        chk_load("wrap_a", 0, 59);
        cur_minutes = 6'd0;
        cur_seconds = 6'd59;
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        chk_load("wrap_b", 59, 0);

        // 4: simultaneous buttons; inc ignored in RUN
        press(0, 1, 0);
        chk("run_inc_mode", mode, 0);
        chk("run_inc_load", load, 0);
        cur_minutes = 6'd10;
        cur_seconds = 6'd20;
        press(1, 0, 0);
        press(0, 1, 1);
        press(1, 1, 0);
        chk("mode_wins", mode, 2);
        press(0, 1, 1);
        press(1, 0, 1);
        chk_load("simul", 10, 20);

        // 5: async reset mid-edit clears everything, no load afterwards
        cur_minutes = 6'd5;
        cur_seconds = 6'd6;
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("pre_rst_mode", mode, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_mode", mode, 0);
        chk("arst_load", load, 0);
        chk("arst_lmin", load_minutes, 0);
        chk("arst_lsec", load_seconds, 0);
        chk("arst_tick", tick_1hz, 0);
        #2;
        reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("post_rst_load", load, 0);
            chk("post_rst_tick", tick_1hz, (i == 8) ? 1 : 0);
        end
        chk("post_rst_lsec", load_seconds, 0);

`ifdef CLK_SET_BLINK_EN
        // 6: blink period 2 cycles in SET_MIN, restart on inc, 0 in RUN
        press(1, 0, 0);
        chk("blink_enter", blink, 0);
        step();
        chk("blink_1", blink, 0);
        step();
        chk("blink_2", blink, 1);
        press(0, 1, 0);
        chk("blink_inc", blink, 0);
        step();
        chk("blink_inc_1", blink, 0);
        step();
        chk("blink_inc_2", blink, 1);
        step();
        chk("blink_inc_3", blink, 1);
        step();
        chk("blink_inc_4", blink, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("blink_run", blink, 0);
            step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
